alu_op_sequencer: RTL and testbench

Issue/collect stage directly upstream of alu_32_bit. Accepts one operation at a time over a valid/ready request interface and drives the ALU operand and opcode inputs from registers. Pulses the ALU reset before a multi-cycle mod operation. Waits a fixed latency per opcode, then captures the ALU result and presents it over a valid/ready response interface.

---
 rtl/alu_op_sequencer.sv | 116 +++++++++++
 tb/tb_alu_op_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue/collect sequencer feeding alu_32_bit
// Registers one request into the ALU, waits the opcode latency, then holds the result for the consumer.
module alu_op_sequencer #(
  parameter logic [2:0] MOD_OP      = 3'b011,
  parameter int         MOD_LATENCY = 33
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_reset,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_op,
  output logic        out_dz,
  output logic        busy
);

  localparam int CW = $clog2(MOD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, EXEC, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            accept;

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_op != MOD_OP)   state_next = EXEC;
          else if (in_b != '0)   state_next = CLEAR;
          else                   state_next = DONE;
        end
      end
      CLEAR:   state_next = EXEC;
      EXEC:    if (cnt == CW'(1)) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !reset;
    busy     = (state != IDLE);
    accept   = in_valid && in_ready;
  end

  // Mod by zero never touches the ALU: the dividend is returned as the result with the dz flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      out_result <= '0;
      out_op     <= '0;
      out_valid  <= 1'b0;
      out_dz     <= 1'b0;
      alu_reset  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          alu_reset <= 1'b0;
          if (accept) begin
            alu_a  <= in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
            out_op <= in_op;
            if (in_op != MOD_OP) begin
              cnt <= CW'(1);
            end else if (in_b != '0) begin
              alu_reset <= 1'b1;
            end else begin
              out_result <= in_a;
              out_dz     <= 1'b1;
              out_valid  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          alu_reset <= 1'b0;
          cnt       <= CW'(MOD_LATENCY);
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_result <= alu_result;
            out_dz     <= 1'b0;
            out_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
// Includes a behavioural ALU (add, delayed mod, xor for other ops) and a per-request reference model.
module tb_alu_op_sequencer;

  localparam logic [2:0] MOD_OP      = 3'b011;
  localparam int         MOD_LATENCY = 33;
  localparam logic [2:0] ADD_OP      = 3'b010;

  logic        CLK = 1'b0;
  logic        reset, in_valid, in_ready, alu_reset, out_valid, out_ready, out_dz, busy;
  logic [31:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic [2:0]  in_op, alu_op, out_op;

  int vectors = 0;
  int miscompares = 0;
  int mod_cnt = 0;
  int ar_high = 0;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(.MOD_OP(MOD_OP), .MOD_LATENCY(MOD_LATENCY)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_reset(alu_reset),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op), .out_dz(out_dz), .busy(busy)
  );

  // Mod result is garbage until the unit has run MOD_LATENCY cycles out of reset.
  always @(posedge CLK) begin
    if (alu_reset) mod_cnt <= 0;
    else if (mod_cnt < 1000) mod_cnt <= mod_cnt + 1;
  end

  always_comb begin
    alu_result = alu_a ^ alu_b;
    if (alu_op == ADD_OP) alu_result = alu_a + alu_b;
    else if (alu_op == MOD_OP)
      alu_result = (mod_cnt >= MOD_LATENCY - 1 && alu_b != 0) ? alu_a % alu_b : 32'hDEAD_BEEF;
  end

  always @(negedge CLK) if (alu_reset) ar_high <= ar_high + 1;

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    if (op != MOD_OP) return 1;
    if (b == 0) return 0;
    return MOD_LATENCY + 1;
  endfunction

  function automatic logic [31:0] exp_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == ADD_OP) return a + b;
    if (op == MOD_OP) return (b == 0) ? a : a % b;
    return a ^ b;
  endfunction

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n = 0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    while (!in_ready && n < 100) begin step(); n++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin step(); lat++; end
  endtask

  task automatic consume();
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    repeat (3) step();
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || alu_reset !== 1'b1 ||
        alu_a !== 0 || alu_b !== 0 || alu_op !== 0 || out_result !== 0 || out_op !== 0 || out_dz !== 0) begin
      miscompares++;
      $display("FAIL reset_state in_ready=%0b busy=%0b out_valid=%0b alu_reset=%0b alu_a=%0h out_result=%0h required 0,0,0,1,0,0",
               in_ready, busy, out_valid, alu_reset, alu_a, out_result);
    end
    reset = 1'b0; #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got=%0b required=1", in_ready); end
    step();
  endtask

  task automatic test_add();
    int lat, ar0;
    ar0 = ar_high;
    send(5, 7, ADD_OP);
    wait_resp(lat);
    vectors++;
    if (lat !== 1 || out_result !== 32'd12 || out_op !== ADD_OP || out_dz !== 1'b0) begin
      miscompares++;
      $display("FAIL add lat=%0d res=%0d op=%0d dz=%0b required 1,12,2,0", lat, out_result, out_op, out_dz);
    end
    consume();
    vectors++;
    if (ar_high !== ar0) begin miscompares++; $display("FAIL add_alu_reset highs=%0d required=0", ar_high - ar0); end
  endtask

  task automatic test_mod();
    int lat = 0, ar0, not_busy = 0;
    send(100, 7, MOD_OP);
    vectors++;
    if (alu_reset !== 1'b1) begin miscompares++; $display("FAIL mod_clear alu_reset=%0b required=1", alu_reset); end
    ar0 = ar_high;
    while (!out_valid && lat < 100) begin
      if (!busy) not_busy++;
      step(); lat++;
    end
    vectors++;
    if (lat !== MOD_LATENCY + 1 || out_result !== 32'd2 || out_dz !== 1'b0 || out_op !== MOD_OP) begin
      miscompares++;
      $display("FAIL mod lat=%0d res=%0d dz=%0b op=%0d required %0d,2,0,3", lat, out_result, out_dz, out_op, MOD_LATENCY + 1);
    end
    vectors++;
    if (ar_high - ar0 !== 1 || not_busy !== 0) begin
      miscompares++;
      $display("FAIL mod_pulse alu_reset_cycles=%0d idle_cycles=%0d required 1,0", ar_high - ar0, not_busy);
    end
    consume();
  endtask

  task automatic test_mod_zero();
    int lat, ar0;
    ar0 = ar_high;
    send(9, 0, MOD_OP);
    wait_resp(lat);
    vectors++;
    if (lat !== 0 || out_result !== 32'd9 || out_dz !== 1'b1 || out_op !== MOD_OP) begin
      miscompares++;
      $display("FAIL mod_zero lat=%0d res=%0d dz=%0b op=%0d required 0,9,1,3", lat, out_result, out_dz, out_op);
    end
    consume();
    vectors++;
    if (ar_high !== ar0) begin miscompares++; $display("FAIL mod_zero_alu_reset highs=%0d required=0", ar_high - ar0); end
  endtask

  task automatic test_backpressure();
    int lat, bad = 0;
    send(3, 4, ADD_OP);
    wait_resp(lat);
    in_a = 32'd50; in_b = 32'd60; in_op = ADD_OP; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_result !== 32'd7 || in_ready !== 1'b0 || out_valid !== 1'b1 || alu_a !== 32'd3) bad++;
      step();
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL backpressure_hold bad_cycles=%0d required=0 res=%0d", bad, out_result); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release in_ready=%0b busy=%0b out_valid=%0b required 1,0,0", in_ready, busy, out_valid);
    end
    step(); in_valid = 1'b0;
    wait_resp(lat);
    vectors++;
    if (lat !== 1 || out_result !== 32'd110) begin
      miscompares++; $display("FAIL backpressure_second lat=%0d res=%0d required 1,110", lat, out_result);
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    send(1000, 13, MOD_OP);
    repeat (14) step();
    reset = 1'b1; step();
    vectors++;
    if (alu_reset !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset alu_reset=%0b out_valid=%0b busy=%0b in_ready=%0b required 1,0,0,0",
               alu_reset, out_valid, busy, in_ready);
    end
    reset = 1'b0; step();
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_after in_ready=%0b busy=%0b out_valid=%0b required 1,0,0", in_ready, busy, out_valid);
    end
    send(5, 7, ADD_OP);
    wait_resp(lat);
    vectors++;
    if (lat !== 1 || out_result !== 32'd12) begin
      miscompares++; $display("FAIL midop_followup lat=%0d res=%0d required 1,12", lat, out_result);
    end
    consume();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  op;
    int lat, sel;
    for (int t = 0; t < 40; t++) begin
      a   = $urandom;
      sel = $urandom_range(0, 3);
      op  = (sel == 0) ? ADD_OP : (sel == 1) ? MOD_OP : 3'($urandom_range(0, 7));
      b   = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      send(a, b, op);
      wait_resp(lat);
      repeat ($urandom_range(0, 3)) step();
      vectors++;
      if (lat !== exp_lat(op, b) || out_result !== exp_res(op, a, b) || out_op !== op ||
          out_dz !== (op == MOD_OP && b == 0) || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%0h b=%0h lat=%0d res=%0h dz=%0b required lat=%0d res=%0h",
                 t, op, a, b, lat, out_result, out_dz, exp_lat(op, b), exp_res(op, a, b));
      end
      consume();
      vectors++;
      if (alu_a !== a || alu_b !== b || alu_op !== op || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL random_hold[%0d] alu_a=%0h alu_b=%0h alu_op=%0d out_valid=%0b required %0h,%0h,%0d,0",
                 t, alu_a, alu_b, alu_op, out_valid, a, b, op);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mod();
    test_mod_zero();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
